alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-slot alarm register bank with built-in ring/snooze control, the successor to the single-alarm register pair. It holds NUM_ALARMS independently editable and armable HH:MM alarm slots, compares the armed slots against the running clock time once per minute, and drives a ringing indication through a RINGING/SNOOZED state machine with snooze and auto-timeout. It sits between the button/debounce front end, the timekeeping counters and the display/buzzer logic.

## Interface
- NUM_ALARMS, 4: number of alarm slots; range 1..16.
- HOUR_MAX, 23: highest hour value. The hour field is 5 bits, so HOUR_MAX ≤ 31.
- MIN_MAX, 59: highest minute value. The minute field is 6 bits, so MIN_MAX ≤ 63.
- SNOOZE_MIN, 5: snooze length in minute ticks; ≥1.
- RING_TIMEOUT_MIN, 10: ring duration in minute ticks before auto-stop; ≥1.
- SEL_W is derived: max(1, $clog2(NUM_ALARMS)).
- Clocking and reset:
  - One clock, sys_clk.
  - Reset is synchronous and active-low, rst_n.
- Ports:
  - sys_clk  in  1: the single clock.
  - rst_n  in  1: synchronous, active-low reset.
  - alarm_sel  in  SEL_W: slot addressed for edit and readback.
  - inc_alarm_hours_en  in  1: one-cycle pulse; steps the selected slot's hours.
  - inc_alarm_minutes_en  in  1: one-cycle pulse; steps the selected slot's minutes.
  - dec_mode  in  1: when 1, the step pulses decrement instead of increment.
  - toggle_arm  in  1: one-cycle pulse; inverts the selected slot's armed bit.
  - cur_hours  in  5: current clock hours.
  - cur_minutes  in  6: current clock minutes.
  - min_tick  in  1: one-cycle pulse in the cycle cur_* shows a new minute.
  - snooze  in  1: one-cycle pulse.
  - stop  in  1: one-cycle pulse.
  - alarm_hours  out  5: selected slot's hours.
  - alarm_minutes  out  6: selected slot's minutes.
  - alarm_armed  out  NUM_ALARMS: armed bit per slot.
  - ringing  out  1: high while in RINGING.
  - ring_id  out  SEL_W: slot that triggered the current ring.

## Operation
- Slot editing:
  - Hours and minutes each wrap independently.
    - Increment: HOUR_MAX→0 and MIN_MAX→0.
    - Decrement: 0→HOUR_MAX and 0→MIN_MAX.
  - A minute wrap never carries into hours.
  - Hour and minute pulses in the same cycle both apply.
  - If alarm_sel ≥ NUM_ALARMS:
    - Edits and toggle_arm are ignored.
    - alarm_hours and alarm_minutes read 0.
- Readback: alarm_hours and alarm_minutes are a combinational mux of the slot registers selected by alarm_sel.
- FSM states: IDLE, RINGING, SNOOZED.
  - IDLE → RINGING: on min_tick, if any armed slot equals {cur_hours, cur_minutes}.
    - Priority goes to the lowest index; ring_id latches that index.
    - The timeout counter clears.
  - RINGING → IDLE, on any of:
    - stop;
    - the timeout counter reaching RING_TIMEOUT_MIN;
    - the ringing slot being disarmed.
  - RINGING → SNOOZED: on snooze; the snooze counter loads SNOOZE_MIN.
  - SNOOZED:
    - Each min_tick decrements the snooze counter.
    - When it goes 1→0: → RINGING, and the timeout counter clears.
    - stop, or disarming the ringing slot: → IDLE.
  - stop and snooze in the same cycle: stop wins.
  - stop and min_tick in the same cycle: stop wins, and there is no re-match that cycle.
  - A slot match during RINGING or SNOOZED is ignored.
  - Editing the ringing slot's time does not end the ring.
  - The armed bit is unaffected by stop or timeout, so the alarm fires again the next day.

## Timing
- Reset values:
  - All slots 00:00 and alarm_armed = 0.
  - FSM in IDLE, so ringing = 0.
  - ring_id = 0 and both counters = 0.
- Reset mid-ring returns the block to IDLE in the next cycle.
- Edit and arm pulses are registered: the result is visible on the outputs in the cycle after the pulse.
- On a match, ringing rises in the cycle after min_tick.
- stop, snooze, timeout and disarm all drop ringing in the cycle after the triggering event.
- Snooze re-ring: ringing rises the cycle after the SNOOZE_MIN-th min_tick following snooze.
- Timeout: ringing falls the cycle after the RING_TIMEOUT_MIN-th min_tick counted in RINGING.
- Input pulses longer than one cycle act once per cycle; the bank does no edge detection.

## Structure
- Package alarm_pkg holds:
  - HOUR_W = 5 and MIN_W = 6;
  - the state enum (IDLE, RINGING, SNOOZED);
  - the wrap-increment and wrap-decrement functions.
- Sub-module alarm_slot, instantiated NUM_ALARMS times:
  - hours/minutes registers and the armed bit;
  - inc/dec logic;
  - the match compare output.
- alarm_bank contains:
  - the select decode;
  - the readback mux;
  - the priority encoder;
  - the FSM and the two counters.

## Test plan
- Reset, then three minute increments on slot 0 → 00:03. Two hour increments → 02:03. 57 more minute increments → 02:00 with hours unchanged.
- Slot 2 with dec_mode=1: hours 0 → 23 and minutes 0 → 59. alarm_sel=1 reads slot 1 at 00:00, and slot 2 reads 23:59.
- Arm slots 1 and 3, both set to 06:30. min_tick with cur = 06:30 → ringing=1 and ring_id=1 the next cycle. The same tick with both disarmed → no ring.
- While ringing, pulse snooze → ringing=0. After 4 min_ticks, still 0. The 5th min_tick → ringing=1 the next cycle.
- Ringing with no input for 10 min_ticks → ringing=0. The slot is still armed, and it fires again at the next matching tick.
- Edge cases:
  - stop and snooze in the same cycle → IDLE, not SNOOZED.
  - Disarming the ringing slot while SNOOZED → IDLE.
  - rst_n low while ringing → all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared widths, ring state encoding and wrap-around step helpers
package alarm_pkg;
  localparam int HOUR_W = 5;
  localparam int MIN_W = 6;
  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;
  function automatic logic [MIN_W-1:0] wrap_inc(input logic [MIN_W-1:0] v, input logic [MIN_W-1:0] max);
    return v == max ? '0 : v + MIN_W'(1);
  endfunction
  function automatic logic [MIN_W-1:0] wrap_dec(input logic [MIN_W-1:0] v, input logic [MIN_W-1:0] max);
    return v == '0 ? max : v - MIN_W'(1);
  endfunction
endpackage

// File: rtl/alarm_slot.sv
// alarm_slot: one editable, armable HH:MM alarm with its match compare
module alarm_slot
  import alarm_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic              inc_hours,
  input  logic              inc_minutes,
  input  logic              dec_mode,
  input  logic              toggle_arm,
  input  logic [HOUR_W-1:0] cur_hours,
  input  logic [MIN_W-1:0]  cur_minutes,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic              armed,
  output logic              armed_nxt,
  output logic              match
);
  logic [HOUR_W-1:0] hours_q, hours_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d, h_step, m_step;
  logic              armed_q, armed_d;
  always_comb begin
    h_step    = dec_mode ? wrap_dec(MIN_W'(hours_q), MIN_W'(HOUR_MAX)) : wrap_inc(MIN_W'(hours_q), MIN_W'(HOUR_MAX));
    m_step    = dec_mode ? wrap_dec(minutes_q, MIN_W'(MIN_MAX)) : wrap_inc(minutes_q, MIN_W'(MIN_MAX));
    hours_d   = sel && inc_hours ? HOUR_W'(h_step) : hours_q;
    minutes_d = sel && inc_minutes ? m_step : minutes_q;
    armed_d   = armed_q ^ (sel && toggle_arm);
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      hours_q   <= '0;
      minutes_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      armed_q   <= armed_d;
    end
  end
  assign hours     = hours_q;
  assign minutes   = minutes_q;
  assign armed     = armed_q;
  assign armed_nxt = armed_d;
  assign match     = armed_q && hours_q == cur_hours && minutes_q == cur_minutes;
endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm registers with ring / snooze / timeout control
module alarm_bank
  import alarm_pkg::*;
#(
  parameter int NUM_ALARMS       = 4,
  parameter int HOUR_MAX         = 23,
  parameter int MIN_MAX          = 59,
  parameter int SNOOZE_MIN       = 5,
  parameter int RING_TIMEOUT_MIN = 10,
  localparam int SEL_W = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  inc_alarm_hours_en,
  input  logic                  inc_alarm_minutes_en,
  input  logic                  dec_mode,
  input  logic                  toggle_arm,
  input  logic [HOUR_W-1:0]     cur_hours,
  input  logic [MIN_W-1:0]      cur_minutes,
  input  logic                  min_tick,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [HOUR_W-1:0]     alarm_hours,
  output logic [MIN_W-1:0]      alarm_minutes,
  output logic [NUM_ALARMS-1:0] alarm_armed,
  output logic                  ringing,
  output logic [SEL_W-1:0]      ring_id
);
  localparam int TW = $clog2(RING_TIMEOUT_MIN + 1);
  localparam int SW = $clog2(SNOOZE_MIN + 1);
  localparam logic [SEL_W:0] N_SLOTS = (SEL_W + 1)'(NUM_ALARMS);
  logic [HOUR_W-1:0]     hrs [NUM_ALARMS];
  logic [MIN_W-1:0]      mins [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] armed_nxt, match, slot_sel;
  logic                  sel_ok, disarm;
  logic [SEL_W-1:0]      hit, ring_id_q, ring_id_d;
  logic [TW-1:0]         to_q, to_d;
  logic [SW-1:0]         sn_q, sn_d;
  state_e                state_q, state_d;
  assign sel_ok = {1'b0, alarm_sel} < N_SLOTS;
  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    assign slot_sel[g] = sel_ok && alarm_sel == SEL_W'(g);
    alarm_slot #(.HOUR_MAX(HOUR_MAX), .MIN_MAX(MIN_MAX)) u_slot (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .sel         (slot_sel[g]),
      .inc_hours   (inc_alarm_hours_en),
      .inc_minutes (inc_alarm_minutes_en),
      .dec_mode    (dec_mode),
      .toggle_arm  (toggle_arm),
      .cur_hours   (cur_hours),
      .cur_minutes (cur_minutes),
      .hours       (hrs[g]),
      .minutes     (mins[g]),
      .armed       (alarm_armed[g]),
      .armed_nxt   (armed_nxt[g]),
      .match       (match[g])
    );
  end
  assign alarm_hours   = sel_ok ? hrs[alarm_sel] : '0;
  assign alarm_minutes = sel_ok ? mins[alarm_sel] : '0;
  always_comb begin
    hit = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) if (match[i]) hit = SEL_W'(i);
  end
  // Disarm looks at the next armed value so the ring drops one cycle after the toggle pulse
  assign disarm = !armed_nxt[ring_id_q];
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ring_id_q <= '0;
      to_q      <= '0;
      sn_q      <= '0;
    end else begin
      state_q   <= state_d;
      ring_id_q <= ring_id_d;
      to_q      <= to_d;
      sn_q      <= sn_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    ring_id_d = ring_id_q;
    to_d      = to_q;
    sn_d      = sn_q;
    case (state_q)
      IDLE: if (!stop && min_tick && |match) begin
        state_d   = RINGING;
        ring_id_d = hit;
        to_d      = '0;
      end
      RINGING: if (stop || disarm) state_d = IDLE;
      else if (snooze) begin
        state_d = SNOOZED;
        sn_d    = SW'(SNOOZE_MIN);
      end else if (min_tick) begin
        to_d    = to_q + TW'(1);
        state_d = to_d == TW'(RING_TIMEOUT_MIN) ? IDLE : RINGING;
      end
      SNOOZED: if (stop || disarm) state_d = IDLE;
      else if (min_tick) begin
        sn_d    = sn_q - SW'(1);
        state_d = sn_q == SW'(1) ? RINGING : SNOOZED;
        to_d    = sn_q == SW'(1) ? '0 : to_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ringing = state_q == RINGING;
    ring_id = ring_id_q;
  end
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: vector table plus hand sequences, scoreboarded against alarm_bank
module tb_alarm_bank;
  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] alarm_sel = '0;
  logic       inc_alarm_hours_en = 0, inc_alarm_minutes_en = 0, dec_mode = 0, toggle_arm = 0;
  logic       min_tick = 0, snooze = 0, stop = 0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic [3:0] alarm_armed;
  logic       ringing;
  logic [1:0] ring_id;
  always #5 sys_clk = ~sys_clk;
  alarm_bank dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .alarm_sel(alarm_sel),
    .inc_alarm_hours_en(inc_alarm_hours_en), .inc_alarm_minutes_en(inc_alarm_minutes_en),
    .dec_mode(dec_mode), .toggle_arm(toggle_arm), .cur_hours(cur_hours), .cur_minutes(cur_minutes),
    .min_tick(min_tick), .snooze(snooze), .stop(stop), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .alarm_armed(alarm_armed), .ringing(ringing), .ring_id(ring_id)
  );
  typedef struct {
    logic rn; logic [1:0] sel; logic ih, im, dec, tog, tick, snz, stp;
    logic [4:0] ch; logic [5:0] cm;
    logic [4:0] eh; logic [5:0] em; logic [3:0] ea; logic er; logic [1:0] eid;
  } vec_t;
  typedef struct {
    logic [4:0] eh; logic [5:0] em; logic [3:0] ea; logic er; logic [1:0] eid; int tag;
  } exp_t;
  exp_t sb[$];
  vec_t tv[$];
  int total = 0, bad = 0, step_no = 0;
  function automatic vec_t mk(logic rn, logic [1:0] sel, logic ih, im, dec, tog, tick, snz, stp,
                              logic [4:0] ch, logic [5:0] cm, logic [4:0] eh, logic [5:0] em,
                              logic [3:0] ea, logic er, logic [1:0] eid);
    vec_t v;
    v.rn = rn; v.sel = sel; v.ih = ih; v.im = im; v.dec = dec; v.tog = tog;
    v.tick = tick; v.snz = snz; v.stp = stp; v.ch = ch; v.cm = cm;
    v.eh = eh; v.em = em; v.ea = ea; v.er = er; v.eid = eid;
    return v;
  endfunction
  // ring-control vector: current time fixed at 06:cm, no time edits
  function automatic vec_t rg(logic [1:0] sel, logic tick, snz, stp, tog, logic [5:0] cm,
                              logic [4:0] eh, logic [5:0] em, logic [3:0] ea, logic er, logic [1:0] eid);
    return mk(1, sel, 0, 0, 0, tog, tick, snz, stp, 5'd6, cm, eh, em, ea, er, eid);
  endfunction
  task automatic cmp(input string what, input int t, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", what, t, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge sys_clk);
    rst_n = v.rn; alarm_sel = v.sel; inc_alarm_hours_en = v.ih; inc_alarm_minutes_en = v.im;
    dec_mode = v.dec; toggle_arm = v.tog; min_tick = v.tick; snooze = v.snz; stop = v.stp;
    cur_hours = v.ch; cur_minutes = v.cm;
    sb.push_back('{v.eh, v.em, v.ea, v.er, v.eid, step_no});
    step_no++;
    @(posedge sys_clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard empty at step %0d", step_no);
    end else begin
      e = sb.pop_front();
      cmp("alarm_hours", e.tag, alarm_hours, e.eh);
      cmp("alarm_minutes", e.tag, alarm_minutes, e.em);
      cmp("alarm_armed", e.tag, alarm_armed, e.ea);
      cmp("ringing", e.tag, ringing, e.er);
      cmp("ring_id", e.tag, ring_id, e.eid);
    end
    rst_n = 1; inc_alarm_hours_en = 0; inc_alarm_minutes_en = 0; toggle_arm = 0;
    min_tick = 0; snooze = 0; stop = 0; dec_mode = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 4'b0000, 0, 0));
    tv.push_back(mk(1, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 23, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 23, 59, 4'b0000, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 23, 59, 4'b0000, 0, 0));
    tv.push_back(mk(1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3, 1, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 59, 4'b0000, 0, 0));
    tv.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2, 59, 4'b0000, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 0));
    tv.push_back(mk(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0));
    repeat (3) @(posedge sys_clk);
    for (int i = 0; i < 6; i++) apply(tv[i]);
    // 57 more minute steps wrap 02:03 to 02:00 without touching hours
    for (int k = 1; k <= 57; k++)
      apply(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 6'((3 + k) % 60), 4'b0000, 0, 0));
    for (int i = 6; i < tv.size(); i++) apply(tv[i]);
    for (int s = 1; s <= 3; s += 2) begin
      for (int k = 1; k <= 6; k++) apply(mk(1, 2'(s), 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(k), 0, 4'b0000, 0, 0));
      for (int k = 1; k <= 30; k++) apply(mk(1, 2'(s), 0, 1, 0, 0, 0, 0, 0, 0, 0, 6, 6'(k), 4'b0000, 0, 0));
    end
    apply(rg(1, 0, 0, 0, 1, 0, 6, 30, 4'b0010, 0, 0));
    apply(rg(3, 0, 0, 0, 1, 0, 6, 30, 4'b1010, 0, 0));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 0, 0, 1, 0, 30, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 0, 0, 0, 1, 30, 6, 30, 4'b1000, 0, 1));
    apply(rg(3, 0, 0, 0, 1, 30, 6, 30, 4'b0000, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b0000, 0, 1));
    apply(rg(1, 0, 0, 0, 1, 30, 6, 30, 4'b0010, 0, 1));
    apply(rg(3, 0, 0, 0, 1, 30, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 1, 0, 30, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 0, 1, 0, 0, 30, 6, 30, 4'b1010, 0, 1));
    for (int k = 1; k <= 4; k++) apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1010, 1, 1));
    apply(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 6, 31, 6, 31, 4'b1010, 1, 1));
    apply(mk(1, 1, 0, 1, 1, 0, 0, 0, 0, 6, 31, 6, 30, 4'b1010, 1, 1));
    for (int k = 1; k <= 9; k++) apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 0, 1, 1, 0, 30, 6, 30, 4'b1010, 0, 1));
    for (int k = 1; k <= 5; k++) apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 0, 1, 0, 0, 30, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 0, 0, 0, 1, 30, 6, 30, 4'b1000, 0, 1));
    for (int k = 1; k <= 5; k++) apply(rg(1, 1, 0, 0, 0, 31, 6, 30, 4'b1000, 0, 1));
    apply(rg(1, 0, 0, 0, 1, 31, 6, 30, 4'b1010, 0, 1));
    apply(rg(1, 1, 0, 0, 0, 30, 6, 30, 4'b1010, 1, 1));
    apply(rg(1, 0, 0, 0, 1, 30, 6, 30, 4'b1000, 0, 1));
    apply(rg(3, 1, 0, 0, 0, 30, 6, 30, 4'b1000, 1, 3));
    apply(mk(0, 3, 0, 0, 0, 0, 0, 0, 0, 6, 30, 0, 0, 4'b0000, 0, 0));
    apply(rg(1, 0, 0, 0, 0, 30, 0, 0, 4'b0000, 0, 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
